// File: rtl/pcseq_pkg.sv
// Shared definitions for the program-counter sequencer: op encoding and next-PC select.
package pcseq_pkg;

   localparam int unsigned OP_W = 3;

   localparam logic [OP_W-1:0] OP_INC    = 3'd0;
   localparam logic [OP_W-1:0] OP_BRANCH = 3'd1;
   localparam logic [OP_W-1:0] OP_JUMP   = 3'd2;
   localparam logic [OP_W-1:0] OP_CALL   = 3'd3;
   localparam logic [OP_W-1:0] OP_RET    = 3'd4;

   typedef enum logic [2:0] {
      SEL_INC,
      SEL_BRANCH,
      SEL_TARGET,
      SEL_TOP,
      SEL_HOLD
   } pc_sel_e;

   // Pointer width that stays legal for a single-entry stack.
   function automatic int unsigned ptr_width(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/pcseq_ras.sv
// Return-address stack for pc_sequencer.
// PCSEQ_STACK_GUARD_EN: refuse push when full / pop when empty and raise sticky flags;
// otherwise the stack is circular and the flags are tied low.
module pcseq_ras
   import pcseq_pkg::*;
#(
   parameter int unsigned PC_WIDTH    = 8,
   parameter int unsigned STACK_DEPTH = 4
) (
   input  logic                               clk,
   input  logic                               clear_n,
   input  logic                               push,
   input  logic                               pop,
   input  logic [PC_WIDTH-1:0]                push_data,
   output logic [PC_WIDTH-1:0]                top_c,
   output logic                               push_ok_c,
   output logic                               pop_ok_c,
   output logic [$clog2(STACK_DEPTH+1)-1:0]   level,
   output logic                               overflow,
   output logic                               underflow
);

   localparam int unsigned PTR_W = ptr_width(STACK_DEPTH);
   localparam int unsigned LVL_W = $clog2(STACK_DEPTH + 1);

   logic [PC_WIDTH-1:0] stack_q [STACK_DEPTH];
   logic [PTR_W-1:0]    sp_q, sp_d, sp_inc, sp_dec;
   logic [LVL_W-1:0]    level_q, level_d;
   logic                full, empty, do_push, do_pop;

   // Pointer wraps modulo STACK_DEPTH, which need not be a power of two.
   always_comb begin
      sp_inc = (sp_q == PTR_W'(STACK_DEPTH - 1)) ? '0 : sp_q + PTR_W'(1);
      sp_dec = (sp_q == '0) ? PTR_W'(STACK_DEPTH - 1) : sp_q - PTR_W'(1);
   end

   assign full  = (level_q == LVL_W'(STACK_DEPTH));
   assign empty = (level_q == '0);
   assign top_c = stack_q[sp_dec];

`ifdef PCSEQ_STACK_GUARD_EN
   assign push_ok_c = ~full;
   assign pop_ok_c  = ~empty;
`else
   assign push_ok_c = 1'b1;
   assign pop_ok_c  = 1'b1;
`endif

   assign do_push = push & push_ok_c;
   assign do_pop  = pop & pop_ok_c;

   // Level saturates at both ends; in circular mode the pointer keeps moving.
   always_comb begin
      sp_d    = sp_q;
      level_d = level_q;
      if (do_push) begin
         sp_d = sp_inc;
         if (!full) level_d = level_q + LVL_W'(1);
      end else if (do_pop) begin
         sp_d = sp_dec;
         if (!empty) level_d = level_q - LVL_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!clear_n) begin
         sp_q    <= '0;
         level_q <= '0;
      end else begin
         sp_q    <= sp_d;
         level_q <= level_d;
      end
   end

   // Storage is deliberately not cleared; only the pointer and level are.
   always_ff @(posedge clk) begin
      if (clear_n && do_push) stack_q[sp_q] <= push_data;
   end

   assign level = level_q;

`ifdef PCSEQ_STACK_GUARD_EN
   logic overflow_q, overflow_d, underflow_q, underflow_d;

   always_comb begin
      overflow_d  = overflow_q | (push & ~push_ok_c);
      underflow_d = underflow_q | (pop & ~pop_ok_c);
   end

   always_ff @(posedge clk) begin
      if (!clear_n) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   assign overflow  = overflow_q;
   assign underflow = underflow_q;
`else
   assign overflow  = 1'b0;
   assign underflow = 1'b0;
`endif

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: next-PC adder/mux, PC register and return-address stack.
// Optional stack guarding is enabled with PCSEQ_STACK_GUARD_EN.
module pc_sequencer
   import pcseq_pkg::*;
#(
   parameter int unsigned          PC_WIDTH     = 8,
   parameter int unsigned          STACK_DEPTH  = 4,
   parameter logic [PC_WIDTH-1:0]  RESET_VECTOR = '0
) (
   input  logic                               Clk,
   input  logic                               Clear_n,
   input  logic                               Stall,
   input  logic [OP_W-1:0]                    Op,
   input  logic [PC_WIDTH-1:0]                Offset,
   input  logic [PC_WIDTH-1:0]                Target,
   output logic [PC_WIDTH-1:0]                PC,
   output logic [$clog2(STACK_DEPTH+1)-1:0]   Stack_Level,
   output logic                               Stack_Overflow,
   output logic                               Stack_Underflow
);

   logic [PC_WIDTH-1:0] pc_q, pc_d, pc_inc, ras_top;
   logic                push_req, pop_req, push_ok, pop_ok;
   pc_sel_e             sel;

   assign pc_inc = pc_q + PC_WIDTH'(1);

   // Refused CALL/RET (guarded build only) fall back to a plain increment.
   always_comb begin
      sel      = SEL_INC;
      push_req = 1'b0;
      pop_req  = 1'b0;
      if (Stall) begin
         sel = SEL_HOLD;
      end else begin
         unique case (Op)
            OP_BRANCH: sel = SEL_BRANCH;
            OP_JUMP:   sel = SEL_TARGET;
            OP_CALL: begin
               push_req = 1'b1;
               sel      = push_ok ? SEL_TARGET : SEL_INC;
            end
            OP_RET: begin
               pop_req = 1'b1;
               sel     = pop_ok ? SEL_TOP : SEL_INC;
            end
            default:   sel = SEL_INC;
         endcase
      end
   end

   always_comb begin
      pc_d = pc_inc;
      unique case (sel)
         SEL_BRANCH: pc_d = pc_q + Offset;
         SEL_TARGET: pc_d = Target;
         SEL_TOP:    pc_d = ras_top;
         SEL_HOLD:   pc_d = pc_q;
         default:    pc_d = pc_inc;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Clear_n) pc_q <= RESET_VECTOR;
      else          pc_q <= pc_d;
   end

   pcseq_ras #(
      .PC_WIDTH    (PC_WIDTH),
      .STACK_DEPTH (STACK_DEPTH)
   ) u_ras (
      .clk       (Clk),
      .clear_n   (Clear_n),
      .push      (push_req),
      .pop       (pop_req),
      .push_data (pc_inc),
      .top_c     (ras_top),
      .push_ok_c (push_ok),
      .pop_ok_c  (pop_ok),
      .level     (Stack_Level),
      .overflow  (Stack_Overflow),
      .underflow (Stack_Underflow)
   );

   assign PC = pc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed plus randomized bench for pc_sequencer against a ring-buffer reference model.
module tb_pc_sequencer;

   localparam int unsigned W  = 8;
   localparam int unsigned D  = 4;
   localparam int unsigned LW = $clog2(D + 1);

   logic          clk = 1'b0;
   logic          clear_n = 1'b0;
   logic          stall = 1'b0;
   logic [2:0]    op = 3'd0;
   logic [W-1:0]  offset = '0;
   logic [W-1:0]  target = '0;
   logic [W-1:0]  pc;
   logic [LW-1:0] level;
   logic          ovf, unf;

   int checks = 0;
   int errors = 0;

   // reference model state
   logic [W-1:0] m_pc;
   int           m_level;
   int           m_sp;
   logic [W-1:0] m_ring [D];
   logic         m_ovf, m_unf;

`ifdef PCSEQ_STACK_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   always #5 clk = ~clk;

   pc_sequencer #(
      .PC_WIDTH     (W),
      .STACK_DEPTH  (D),
      .RESET_VECTOR (8'h00)
   ) dut (
      .Clk             (clk),
      .Clear_n         (clear_n),
      .Stall           (stall),
      .Op              (op),
      .Offset          (offset),
      .Target          (target),
      .PC              (pc),
      .Stack_Level     (level),
      .Stack_Overflow  (ovf),
      .Stack_Underflow (unf)
   );

   // Apply the specification's rules for one clock to the model.
   task automatic model_step();
      if (!clear_n) begin
         m_pc = 8'h00; m_level = 0; m_sp = 0; m_ovf = 1'b0; m_unf = 1'b0;
      end else if (!stall) begin
         case (op)
            3'd1: m_pc = m_pc + offset;
            3'd2: m_pc = target;
            3'd3: begin
               if (GUARD && m_level == D) begin
                  m_pc = m_pc + 8'd1; m_ovf = 1'b1;
               end else begin
                  m_ring[m_sp] = m_pc + 8'd1;
                  m_sp = (m_sp + 1) % D;
                  if (m_level < D) m_level++;
                  m_pc = target;
               end
            end
            3'd4: begin
               if (GUARD && m_level == 0) begin
                  m_pc = m_pc + 8'd1; m_unf = 1'b1;
               end else begin
                  m_sp = (m_sp + D - 1) % D;
                  m_pc = m_ring[m_sp];
                  if (m_level > 0) m_level--;
               end
            end
            default: m_pc = m_pc + 8'd1;
         endcase
      end
   endtask

   task automatic check_model(input string tag);
      checks++;
      assert (pc === m_pc) else begin
         errors++; $error("FAIL %s pc: observed %h expected %h", tag, pc, m_pc);
      end
      checks++;
      assert (level === LW'(m_level)) else begin
         errors++; $error("FAIL %s level: observed %0d expected %0d", tag, level, m_level);
      end
      checks++;
      assert (ovf === m_ovf) else begin
         errors++; $error("FAIL %s overflow: observed %b expected %b", tag, ovf, m_ovf);
      end
      checks++;
      assert (unf === m_unf) else begin
         errors++; $error("FAIL %s underflow: observed %b expected %b", tag, unf, m_unf);
      end
   endtask

   task automatic expect_pc(input string tag, input logic [W-1:0] exp_pc, input int exp_lvl);
      checks++;
      assert (pc === exp_pc) else begin
         errors++; $error("FAIL %s pc: observed %h expected %h", tag, pc, exp_pc);
      end
      checks++;
      assert (level === LW'(exp_lvl)) else begin
         errors++; $error("FAIL %s level: observed %0d expected %0d", tag, level, exp_lvl);
      end
   endtask

   // Drive, clock once, then compare against the model away from the edge.
   task automatic step(input logic c_n, input logic st, input logic [2:0] o,
                       input logic [W-1:0] off, input logic [W-1:0] tgt, input string tag);
      clear_n = c_n; stall = st; op = o; offset = off; target = tgt;
      model_step();
      @(posedge clk);
      #1;
      check_model(tag);
   endtask

   initial begin
      // 1: reset wins over JUMP, then three increments
      step(1'b0, 1'b0, 3'd2, 8'h00, 8'h55, "reset");
      expect_pc("reset_const", 8'h00, 0);
      checks++;
      assert (ovf === 1'b0 && unf === 1'b0) else begin
         errors++; $error("FAIL reset_flags: observed %b%b expected 00", ovf, unf);
      end
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 3'd0, 8'h00, 8'h00, "inc");
      expect_pc("inc3", 8'h03, 0);

      // 2: wrap-around in both directions
      step(1'b1, 1'b0, 3'd2, 8'h00, 8'hFF, "jump_ff");
      step(1'b1, 1'b0, 3'd0, 8'h00, 8'h00, "inc_wrap");
      expect_pc("inc_wrap_const", 8'h00, 0);
      step(1'b1, 1'b0, 3'd1, 8'hFE, 8'h00, "branch_neg");
      expect_pc("branch_neg_const", 8'hFE, 0);

      // 3: stall holds everything even with CALL presented
      step(1'b1, 1'b0, 3'd2, 8'h00, 8'h10, "jump_10");
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b1, 3'd3, 8'h00, 8'h77, "stall");
         expect_pc("stall_const", 8'h10, 0);
      end

      // 4: nested call/return
      step(1'b1, 1'b0, 3'd2, 8'h00, 8'h20, "jump_20");
      step(1'b1, 1'b0, 3'd3, 8'h00, 8'h40, "call_40");
      step(1'b1, 1'b0, 3'd3, 8'h00, 8'h60, "call_60");
      expect_pc("nest_lvl2", 8'h60, 2);
      step(1'b1, 1'b0, 3'd4, 8'h00, 8'h00, "ret1");
      expect_pc("ret1_const", 8'h41, 1);
      step(1'b1, 1'b0, 3'd4, 8'h00, 8'h00, "ret2");
      expect_pc("ret2_const", 8'h21, 0);

      // 5: push past full, pop past empty
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 3'd3, 8'h00, 8'h80 + 8'(i), "call_x5");
`ifdef PCSEQ_STACK_GUARD_EN
      expect_pc("ovf_pc", 8'h84, 4);
      checks++;
      assert (ovf === 1'b1) else begin
         errors++; $error("FAIL ovf_flag: observed %b expected 1", ovf);
      end
`else
      expect_pc("circ_pc", 8'h84, 4);
`endif
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 3'd4, 8'h00, 8'h00, "ret_x5");
`ifdef PCSEQ_STACK_GUARD_EN
      checks++;
      assert (unf === 1'b1) else begin
         errors++; $error("FAIL unf_flag: observed %b expected 1", unf);
      end
`endif

      // 6: reset in the middle of a deep call chain
      step(1'b0, 1'b0, 3'd0, 8'h00, 8'h00, "clr");
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 3'd3, 8'h00, 8'h30 + 8'(i), "call_x3");
      expect_pc("lvl3", 8'h32, 3);
      step(1'b0, 1'b0, 3'd4, 8'h00, 8'h00, "mid_reset");
      expect_pc("mid_reset_const", 8'h00, 0);
      step(1'b1, 1'b0, 3'd4, 8'h00, 8'h00, "ret_after_reset");

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 31) != 0), ($urandom_range(0, 7) == 0),
              3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), "random");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
